serial_subtractor_ctrl: RTL
===========================

Name: serial_subtractor_ctrl

Overview:
Bit-serial N-bit subtractor controller that computes diff = a - b one bit per clock, LSB first.
- Datapath is a single 1-bit full-subtract cell built from two half-subtractor stages plus a borrow flop.
- The controller sequences that datapath: operand latching, bit indexing, borrow chaining, result assembly and the start/done handshake.
- Used wherever area matters more than latency. It is the multi-bit front end for the team's 1-bit subtractor cells.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; latched on accepted start.
- b  input  WIDTH  subtrahend; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse in the DONE state.
- d  output  WIDTH  difference, a - b mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b unsigned.

Behaviour:
Reset and state:
- Reset (sync, active-high, wins over everything): state=IDLE; busy=0, done=0, d=0, bout=0; borrow flop=0; counter=0.
- FSM states: IDLE, RUN, DONE. Encoding is 2 bits, defined in the package.

IDLE:
- If start=1 at a clock edge: latch a, b into shift registers; clear the borrow flop; counter=0; go to RUN.
- d and bout are not cleared on start. They hold the previous result until DONE.

RUN (one bit per cycle, LSB first):
- Per-bit cell inputs: ai=a_sh[0], bi=b_sh[0], br=borrow flop.
- Stage 1: d1=ai^bi, b1=~ai&bi.
- Stage 2: dbit=d1^br, b2=~d1&br.
- Borrow update: borrow_next=b1|b2.
- On each edge:
  - shift dbit into the result register at the MSB end; after WIDTH shifts the LSB is aligned.
  - shift a_sh and b_sh right by 1.
  - counter+1.
- When counter==WIDTH-1 at the edge: go to DONE. This edge also commits the last bit.

DONE (exactly one cycle):
- done=1; d=assembled result; bout=final borrow.
- Next edge goes to IDLE unconditionally.

Latency and handshake:
- If start is accepted at edge k, done is high during the cycle after edge k+WIDTH.
- Throughput is one op per WIDTH+2 cycles.
- A back-to-back start may be asserted during DONE, but it is ignored. It is accepted on the following IDLE cycle if still high.
- start during RUN or DONE: ignored; latched operands are unaffected. Changes on a/b outside the accepting edge: no effect.
- Reset asserted mid-RUN: abort; all outputs and state go to their reset values. No done pulse.

Boundary and width rules:
- WIDTH=1: RUN lasts one cycle.
- Wrap-around: 0 - 1 gives d = all-ones, bout=1.
- Equal operands give d=0, bout=0.
- All arithmetic is unsigned modulo 2^WIDTH.

Optional Feature:
Macro SERIAL_SUB_SIGNED_OVF_EN.
- Defined: adds output ovf (1 bit).
  - Signed overflow = (a_msb ^ b_msb) & (a_msb ^ d_msb), evaluated on the final RUN bit.
  - Registered; valid in DONE; held until the next DONE; 0 on reset.
- Undefined: no ovf port, no extra logic. All other behaviour is identical.

Decomposition:
- Package serial_sub_pkg holds:
  - the state typedef/localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2);
  - the default WIDTH constant.
- One sub-module: sub_bit_cell. It is the combinational 1-bit full subtractor (two half-subtract stages), with ports ai, bi, br, dbit, brout.
- The controller instantiates sub_bit_cell once and owns all state.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start 1 cycle -> busy high 8 cycles; done pulse at cycle 9 after the start edge; d=0x02, bout=0.
- a=0x03, b=0x05 -> d=0xFE, bout=1. Then a=0x00, b=0x01 -> d=0xFF, bout=1. Then a=0x5A, b=0x5A -> d=0x00, bout=0.
- start held high continuously with a=0xFF, b=0x01 -> results d=0xFE, bout=0 every 10 cycles. Operand changes during RUN do not alter the result.
- rst asserted at RUN bit 4 of a=0x80, b=0x01 -> next cycle state=IDLE, busy=0, d=0, bout=0; no done pulse. A fresh start then gives d=0x7F.
- WIDTH=1 build, exhaustive a,b in {0,1} -> (0,0)->d0 b0, (0,1)->d1 b1, (1,0)->d1 b0, (1,1)->d0 b0; done 2 cycles after the start edge.
- SERIAL_SUB_SIGNED_OVF_EN build, a=0x80, b=0x01 -> d=0x7F, bout=0, ovf=1. a=0x7F, b=0x01 -> ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_bit_cell.sv
// Combinational 1-bit full subtractor: ai - bi - br, built from two half-subtract stages.
module sub_bit_cell (
    input  logic ai,
    input  logic bi,
    input  logic br,
    output logic dbit,
    output logic brout
);

    logic d1;
    logic b1;
    logic b2;

    assign d1    = ai ^ bi;
    assign b1    = ~ai & bi;
    assign dbit  = d1 ^ br;
    assign b2    = ~d1 & br;
    assign brout = b1 | b2;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b controller, LSB first, one bit per clock through a single sub_bit_cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_d;
    logic [WIDTH-1:0]   dbit_msb;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   d_q;
    logic               bout_q;
    logic               last_bit;
    logic               cell_dbit;
    logic               cell_brout;

    sub_bit_cell u_cell (
        .ai    (a_sh_q[0]),
        .bi    (b_sh_q[0]),
        .br    (borrow_q),
        .dbit  (cell_dbit),
        .brout (cell_brout)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    always_comb begin
        dbit_msb            = '0;
        dbit_msb[WIDTH-1]   = cell_dbit;
        res_d               = (res_q >> 1) | dbit_msb;
    end

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic ovf_q;
    // On the last bit the cell sees the operand MSBs and produces the result MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_RUN && last_bit) begin
            ovf_q <= (a_sh_q[0] ^ b_sh_q[0]) & (a_sh_q[0] ^ cell_dbit);
        end
    end
    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= cell_brout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_bit) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        d_q     <= res_d;
                        bout_q  <= cell_brout;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule
